// File: rtl/rc4_key_dispatcher.sv
// Dynamic key-space scheduler for the multicore RC4 cracker: grants contiguous key
// chunks round-robin to requesting cores, resolves finds and detects exhaustion.
module rc4_key_dispatcher #(
    parameter int                   NUM_CORES  = 4,
    parameter int                   KEY_WIDTH  = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX    = 24'h3FFFFF,
    parameter int                   CHUNK_SIZE = 4096,
    parameter int                   IDX_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [NUM_CORES-1:0]           core_req,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_found,
    input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    output logic [NUM_CORES-1:0]           core_gnt,
    output logic [KEY_WIDTH-1:0]           chunk_base,
    output logic [KEY_WIDTH-1:0]           chunk_last,
    output logic                           abort,
    output logic                           busy,
    output logic                           found,
    output logic                           exhausted,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [IDX_W-1:0]               found_core,
    output logic [KEY_WIDTH-1:0]           chunks_issued
);

    // One extra bit so the base increment past the top of the key space keeps its carry.
    localparam int             SW      = KEY_WIDTH + 1;
    localparam logic [SW-1:0]  MAX_X   = {1'b0, KEY_MAX};
    localparam logic [SW-1:0]  CHUNK_X = SW'(CHUNK_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FOUND,
        S_EXHAUSTED
    } state_t;

    state_t               state, state_n;
    logic [SW-1:0]        next_base, next_base_n;
    logic [NUM_CORES-1:0] outstanding, outstanding_n;
    logic [NUM_CORES-1:0] req_q;
    logic [IDX_W-1:0]     ptr, ptr_n;
    logic [NUM_CORES-1:0] gnt_n;
    logic [KEY_WIDTH-1:0] base_n, last_n, fkey_n, issued_n;
    logic [IDX_W-1:0]     fcore_n;
    logic [NUM_CORES-1:0] eligible, valid_find;
    logic [SW-1:0]        base_plus, last_raw;

    assign eligible   = req_q & ~outstanding;
    assign valid_find = core_found & outstanding;
    assign base_plus  = next_base + CHUNK_X;
    assign last_raw   = base_plus - SW'(1);

    assign abort     = (state == S_FOUND);
    assign found     = (state == S_FOUND);
    assign exhausted = (state == S_EXHAUSTED);
    assign busy      = (state == S_RUN) || (state == S_DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            next_base     <= '0;
            outstanding   <= '0;
            req_q         <= '0;
            ptr           <= '0;
            core_gnt      <= '0;
            chunk_base    <= '0;
            chunk_last    <= '0;
            found_key     <= '0;
            found_core    <= '0;
            chunks_issued <= '0;
        end else begin
            state         <= state_n;
            next_base     <= next_base_n;
            outstanding   <= outstanding_n;
            req_q         <= core_req;
            ptr           <= ptr_n;
            core_gnt      <= gnt_n;
            chunk_base    <= base_n;
            chunk_last    <= last_n;
            found_key     <= fkey_n;
            found_core    <= fcore_n;
            chunks_issued <= issued_n;
        end
    end

    always_comb begin : next_p
        int  idx;
        int  pick;
        int  win;
        logic pick_ok;
        logic win_ok;
        state_n       = state;
        next_base_n   = next_base;
        outstanding_n = outstanding;
        ptr_n         = ptr;
        gnt_n         = '0;
        base_n        = chunk_base;
        last_n        = chunk_last;
        fkey_n        = found_key;
        fcore_n       = found_core;
        issued_n      = chunks_issued;
        idx           = 0;
        pick          = 0;
        pick_ok       = 1'b0;
        win           = 0;
        win_ok        = 1'b0;

        // Round-robin search starting at the pointer.
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!pick_ok && eligible[idx]) begin
                pick_ok = 1'b1;
                pick    = idx;
            end
        end
        // Lowest index valid finder wins.
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (valid_find[k]) begin
                win_ok = 1'b1;
                win    = k;
            end
        end

        case (state)
            S_IDLE, S_FOUND, S_EXHAUSTED: begin
                if (start) begin
                    state_n       = S_RUN;
                    next_base_n   = '0;
                    outstanding_n = '0;
                    fkey_n        = '0;
                    fcore_n       = '0;
                    issued_n      = '0;
                end
            end
            S_RUN, S_DRAIN: begin
                if (win_ok) begin
                    state_n = S_FOUND;
                    fkey_n  = core_key[win*KEY_WIDTH +: KEY_WIDTH];
                    fcore_n = IDX_W'(win);
                end else begin
                    outstanding_n = outstanding & ~core_done;
                    if (state == S_RUN && pick_ok) begin
                        gnt_n[pick]         = 1'b1;
                        outstanding_n[pick] = 1'b1;
                        base_n              = next_base[KEY_WIDTH-1:0];
                        last_n              = (last_raw > MAX_X) ? KEY_MAX : last_raw[KEY_WIDTH-1:0];
                        next_base_n         = base_plus;
                        issued_n            = chunks_issued + KEY_WIDTH'(1);
                        ptr_n               = (pick == NUM_CORES - 1) ? '0 : IDX_W'(pick + 1);
                        if (base_plus > MAX_X) state_n = S_DRAIN;
                    end else if (state == S_DRAIN && outstanding_n == '0) begin
                        state_n = S_EXHAUSTED;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rc4_key_dispatcher.sv
// Bench for rc4_key_dispatcher: directed steps plus randomized core behaviour,
// every output compared each cycle against a reference model of the scheduling rules.
module tb_rc4_key_dispatcher;

    localparam int NC   = 4;
    localparam int KW   = 24;
    localparam int KMAX = 'hA8;
    localparam int CS   = 16;
    localparam int IW   = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_FOUND = 3;
    localparam int M_EXH   = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [NC-1:0]    core_req;
    logic [NC-1:0]    core_done;
    logic [NC-1:0]    core_found;
    logic [NC*KW-1:0] core_key;
    logic [NC-1:0]    core_gnt;
    logic [KW-1:0]    chunk_base;
    logic [KW-1:0]    chunk_last;
    logic             abort;
    logic             busy;
    logic             found;
    logic             exhausted;
    logic [KW-1:0]    found_key;
    logic [IW-1:0]    found_core;
    logic [KW-1:0]    chunks_issued;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_mode;
    logic [NC-1:0] m_out;
    logic [NC-1:0] m_reqq;
    logic [NC-1:0] m_gnt;
    int            m_next, m_ptr, m_base, m_last, m_fkey, m_fcore, m_issued;

    // Core behaviour state
    int ttl [NC];
    int gap [NC];
    bit find_en;

    rc4_key_dispatcher #(
        .NUM_CORES (NC),
        .KEY_WIDTH (KW),
        .KEY_MAX   (24'hA8),
        .CHUNK_SIZE(CS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .core_req     (core_req),
        .core_done    (core_done),
        .core_found   (core_found),
        .core_key     (core_key),
        .core_gnt     (core_gnt),
        .chunk_base   (chunk_base),
        .chunk_last   (chunk_last),
        .abort        (abort),
        .busy         (busy),
        .found        (found),
        .exhausted    (exhausted),
        .found_key    (found_key),
        .found_core   (found_core),
        .chunks_issued(chunks_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_out = '0; m_reqq = '0; m_gnt = '0;
        m_next = 0; m_ptr = 0; m_base = 0; m_last = 0;
        m_fkey = 0; m_fcore = 0; m_issued = 0;
    endtask

    // Applies one clock edge worth of scheduling rules to the model.
    task automatic model_edge();
        logic [NC-1:0] vf;
        logic [NC-1:0] elig;
        int pick;
        m_gnt = '0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_mode == M_IDLE || m_mode == M_FOUND || m_mode == M_EXH) begin
            if (start) begin
                m_mode = M_RUN; m_next = 0; m_out = '0;
                m_fkey = 0; m_fcore = 0; m_issued = 0;
            end
        end else begin
            vf   = core_found & m_out;
            elig = m_reqq & ~m_out;
            if (vf != '0) begin
                for (int i = NC - 1; i >= 0; i--) if (vf[i]) m_fcore = i;
                m_fkey = int'(core_key[m_fcore*KW +: KW]);
                m_mode = M_FOUND;
            end else begin
                m_out = m_out & ~core_done;
                if (m_mode == M_RUN && elig != '0) begin
                    pick = -1;
                    for (int k = 0; k < NC; k++)
                        if (pick < 0 && elig[(m_ptr + k) % NC]) pick = (m_ptr + k) % NC;
                    m_gnt[pick] = 1'b1;
                    m_out[pick] = 1'b1;
                    m_base = m_next;
                    m_last = (m_next + CS - 1 > KMAX) ? KMAX : m_next + CS - 1;
                    m_next = m_next + CS;
                    m_issued++;
                    m_ptr = (pick + 1) % NC;
                    if (m_next > KMAX) m_mode = M_DRAIN;
                end else if (m_mode == M_DRAIN && m_out == '0) begin
                    m_mode = M_EXH;
                end
            end
        end
        m_reqq = core_req;
    endtask

    task automatic compare_all();
        chk("gnt", 32'(core_gnt), 32'(m_gnt));
        if (m_gnt != '0) begin
            chk("chunk_base", 32'(chunk_base), m_base);
            chk("chunk_last", 32'(chunk_last), m_last);
        end
        chk("busy", 32'(busy), 32'(m_mode == M_RUN || m_mode == M_DRAIN));
        chk("found", 32'(found), 32'(m_mode == M_FOUND));
        chk("abort", 32'(abort), 32'(m_mode == M_FOUND));
        chk("exhausted", 32'(exhausted), 32'(m_mode == M_EXH));
        chk("found_key", 32'(found_key), m_fkey);
        chk("found_core", 32'(found_core), m_fcore);
        chk("chunks_issued", 32'(chunks_issued), m_issued);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic init_cores();
        for (int i = 0; i < NC; i++) begin
            ttl[i] = -1;
            gap[i] = -1;
        end
    endtask

    // Behaviour of the crack cores for the cycle following a tick.
    task automatic drive_cores();
        core_done  = '0;
        core_found = '0;
        start      = 1'b0;
        for (int i = 0; i < NC; i++) begin
            if (m_gnt[i]) begin
                core_req[i] = 1'b0;
                ttl[i] = int'($urandom_range(1, 6));
            end else if (ttl[i] > 0) begin
                ttl[i]--;
                if (ttl[i] == 0) begin
                    ttl[i] = -1;
                    gap[i] = int'($urandom_range(0, 2));
                    core_key[i*KW +: KW] = KW'($urandom);
                    if (find_en && $urandom_range(0, 19) == 0) core_found[i] = 1'b1;
                    else core_done[i] = 1'b1;
                end
            end else begin
                if (!core_req[i] && gap[i] >= 0) begin
                    if (gap[i] == 0) begin
                        core_req[i] = 1'b1;
                        gap[i] = -1;
                    end else gap[i]--;
                end
                if (!m_out[i] && $urandom_range(0, 15) == 0) begin
                    core_key[i*KW +: KW] = KW'($urandom);
                    if ($urandom_range(0, 1) == 1) core_found[i] = 1'b1;
                    else core_done[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic start_sweep(input logic [NC-1:0] req_init);
        init_cores();
        core_req   = req_init;
        core_done  = '0;
        core_found = '0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_abort", 32'(abort), 0);
    endtask

    task automatic run_auto(input bit fe, input int budget);
        find_en = fe;
        for (int n = 0; n < budget; n++) begin
            drive_cores();
            tick();
            if (m_mode == M_FOUND || m_mode == M_EXH) break;
        end
        core_done  = '0;
        core_found = '0;
        chk("sweep_end", 32'(found | exhausted), 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        core_req = '0; core_done = '0; core_found = '0; core_key = '0;
        find_en = 1'b0;
        model_reset();
        init_cores();

        // Reset state
        tick();
        tick();
        chk("rst_chunk_base", 32'(chunk_base), 0);
        chk("rst_chunk_last", 32'(chunk_last), 0);
        rst_n = 1'b1;

        // All four cores request together: round-robin grants on consecutive cycles
        core_req = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NC; i++) begin
            tick();
            chk("rr_gnt", 32'(core_gnt), 32'(1) << i);
            chk("rr_base", 32'(chunk_base), i * CS);
            core_req[i] = 1'b0;
        end

        // Core 2 returns and re-requests: it alone gets the next chunk
        core_done = 4'b0100;
        tick();
        core_done = '0;
        core_req[2] = 1'b1;
        tick();
        tick();
        chk("regrant_gnt", 32'(core_gnt), 32'b0100);
        chk("regrant_base", 32'(chunk_base), 4 * CS);
        core_req[2] = 1'b0;

        // Core 0 frees up and requests while cores 1 and 3 find simultaneously
        core_done = 4'b0001;
        tick();
        core_done = '0;
        core_req[0] = 1'b1;
        tick();
        core_found = 4'b1010;
        core_key[1*KW +: KW] = 24'h000ABC;
        core_key[3*KW +: KW] = 24'h123456;
        tick();
        core_found = '0;
        chk("find_no_gnt", 32'(core_gnt), 0);
        chk("find_core", 32'(found_core), 1);
        chk("find_key", 32'(found_key), 32'h000ABC);
        chk("find_abort", 32'(abort), 1);

        // Restart from FOUND, random sweep with finds allowed
        start_sweep('1);
        run_auto(1'b1, 600);

        // Spurious find from a non-outstanding core is ignored, then sweep to exhaustion
        start_sweep('0);
        core_found = 4'b0001;
        core_key[0 +: KW] = 24'h55AA55;
        tick();
        core_found = '0;
        chk("spurious_busy", 32'(busy), 1);
        chk("spurious_found", 32'(found), 0);
        core_req = '1;
        run_auto(1'b0, 600);
        chk("exh_flag", 32'(exhausted), 1);
        chk("exh_issued", 32'(chunks_issued), 11);

        // Reset in the middle of a sweep after five grants
        start_sweep('1);
        find_en = 1'b0;
        for (int n = 0; n < 200 && m_issued < 5; n++) begin
            drive_cores();
            tick();
        end
        core_done = '0; core_found = '0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(core_gnt), 0);
        chk("mid_rst_abort", 32'(abort), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_issued", 32'(chunks_issued), 0);
        chk("mid_rst_base", 32'(chunk_base), 0);
        chk("mid_rst_last", 32'(chunk_last), 0);
        tick();
        tick();
        rst_n = 1'b1;
        init_cores();
        core_req = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("post_rst_gnt", 32'(core_gnt), 32'b0001);
        chk("post_rst_base", 32'(chunk_base), 0);
        // Single active core sweeps the whole space alone
        run_auto(1'b0, 800);
        chk("single_exh", 32'(exhausted), 1);
        chk("single_issued", 32'(chunks_issued), 11);

        // Randomized sweeps
        for (int s = 0; s < 6; s++) begin
            start_sweep(NC'($urandom_range(1, 15)));
            run_auto(bit'($urandom_range(0, 1)), 800);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
